// File: rtl/spi_seq_pkg.sv
// FSM state encodings for the spi_seq sequencer.
package spi_seq_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_SETUP = 3'd1;
  localparam logic [ST_W-1:0] ST_RUN   = 3'd2;
  localparam logic [ST_W-1:0] ST_WAIT  = 3'd3;
  localparam logic [ST_W-1:0] ST_HOLD  = 3'd4;

endpackage

// File: rtl/spi_seq_tick_div.sv
// Prescaler for spi_seq: loadable down-counter that emits a tick every load_i+1
// enabled clocks; clr_i restarts the period from load_i.
module spi_seq_tick_div #(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic [DW-1:0] load_i,
  output logic          tick_o
);

  logic [DW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = load_i;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? load_i : cnt_q - DW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/spi_seq.sv
// Transaction sequencer for the bitbang shift engine: frames cs_n, generates sck
// and issues engine step pulses. SPI_SEQ_CPOL_EN adds a cpol_i input (mode 2).
//
// state | meaning
// IDLE  | no transaction, cs_n high, sck at idle level
// SETUP | cs_n asserted, waiting for a tick with a word available (load step)
// RUN   | sck toggles on each tick, step on every falling edge
// WAIT  | word boundary with empty tx queue, sck held at idle
// HOLD  | one tick of idle sck before releasing cs_n
module spi_seq
  import spi_seq_pkg::*;
#(
  parameter int W  = 16,
  parameter int DW = 8,
  parameter int LW = 8
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic [DW-1:0] div_i,
  input  logic [LW-1:0] len_i,
  input  logic          start_i,
  input  logic          avail_i,
`ifdef SPI_SEQ_CPOL_EN
  input  logic          cpol_i,
`endif
  output logic          busy_o,
  output logic          done_o,
  output logic          step_o,
  output logic          cs_n_o,
  output logic          sck_o
);

  localparam int BW = $clog2(W + 1);

  logic [ST_W-1:0] state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [LW-1:0]   words_q, words_d;
  logic [BW-1:0]   bits_q, bits_d;
  logic            sck_q, sck_d;
  logic            cs_n_q;
  logic            tick;

  spi_seq_tick_div #(.DW(DW)) u_tick_div (
    .clk_i  (clock_i),
    .rst_i  (reset_i),
    .en_i   (state_q != ST_IDLE),
    .clr_i  (state_d != state_q),
    .load_i (div_d),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    words_d = words_q;
    bits_d  = bits_q;
    sck_d   = sck_q;
    step_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SETUP;
          div_d   = div_i;
          words_d = (len_i == '0) ? LW'(1) : len_i;
          bits_d  = BW'(W);
          sck_d   = 1'b0;
        end
      end
      ST_SETUP: begin
        if (tick && avail_i) begin
          step_o  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tick) begin
          sck_d = ~sck_q;
          if (sck_q) begin
            step_o = 1'b1;
            if (bits_q == BW'(1)) begin
              if (words_q == LW'(1)) begin
                state_d = ST_HOLD;
              end else begin
                // the boundary step is issued here even if we stall afterwards
                bits_d  = BW'(W);
                words_d = words_q - LW'(1);
                if (!avail_i) state_d = ST_WAIT;
              end
            end else begin
              bits_d = bits_q - BW'(1);
            end
          end
        end
      end
      ST_WAIT: begin
        if (tick && avail_i) begin
          sck_d   = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (tick) begin
          done_o  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      words_q <= '0;
      bits_q  <= '0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      words_q <= words_d;
      bits_q  <= bits_d;
      sck_q   <= sck_d;
      cs_n_q  <= (state_q == ST_IDLE);
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign cs_n_o = cs_n_q;

`ifdef SPI_SEQ_CPOL_EN
  logic cpol_q;

  always_ff @(posedge clock_i) begin
    if (reset_i)                           cpol_q <= 1'b0;
    else if (state_q == ST_IDLE && start_i) cpol_q <= cpol_i;
  end

  assign sck_o = sck_q ^ cpol_q;
`else
  assign sck_o = sck_q;
`endif

endmodule

// File: tb/tb_spi_seq.sv
// Self-checking bench for spi_seq: a small engine model shifts tx words out on
// steps, samples on rising sck, and a scoreboard compares each received word.
module tb_spi_seq;

  localparam int W  = 16;
  localparam int DW = 8;
  localparam int LW = 8;

  logic          clk_i = 1'b0;
  logic          reset_i, start_i, avail_i;
  logic [DW-1:0] div_i;
  logic [LW-1:0] len_i;
  logic          busy_o, done_o, step_o, cs_n_o, sck_o;

  spi_seq #(.W(W), .DW(DW), .LW(LW)) dut (
    .clock_i (clk_i),
    .reset_i (reset_i),
    .div_i   (div_i),
    .len_i   (len_i),
    .start_i (start_i),
    .avail_i (avail_i),
`ifdef SPI_SEQ_CPOL_EN
    .cpol_i  (1'b0),
`endif
    .busy_o  (busy_o),
    .done_o  (done_o),
    .step_o  (step_o),
    .cs_n_o  (cs_n_o),
    .sck_o   (sck_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // scoreboard and engine model state
  logic [W-1:0] tx_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] tx_sh = '0;
  logic [W-1:0] rx_sh = '0;
  logic eng_clr = 1'b1;
  int   cur_div = 0, exp_per = 0;
  int   cyc = 0, steps = 0, rises = 0, dones = 0;
  int   gap_bad = 0, step_bad = 0, csn_bad = 0;
  int   last_rise = 0, last_step = 0, done_cyc = 0;
  int   rcnt = 0, ecnt = 0, rise_in_txn = 0;
  bit   first = 1'b1, sck_prev = 1'b0, step_prev = 1'b0;

  always @(negedge clk_i) begin
    cyc++;
    if (eng_clr) begin
      rx_sh = '0; rcnt = 0; ecnt = 0; first = 1'b1;
      rise_in_txn = 0; sck_prev = 1'b0; step_prev = 1'b0;
    end else begin
      if (sck_o && !sck_prev) begin
        rises++;
        if (cs_n_o) csn_bad++;
        if (rise_in_txn > 0 && exp_per != 0 && cyc - last_rise != exp_per) gap_bad++;
        rise_in_txn++;
        last_rise = cyc;
        rx_sh = {rx_sh[W-2:0], tx_sh[W-1]};
        rcnt++;
        if (rcnt == W) begin
          rcnt = 0;
          if (exp_q.size() == 0) check("sb_underflow", 1, 0);
          else                   check("rx_word", rx_sh, exp_q.pop_front());
        end
      end
      if (step_o) begin
        steps++;
        if ((step_prev && cur_div != 0) || !busy_o) step_bad++;
        last_step = cyc;
        if (first) begin
          first = 1'b0;
          ecnt  = 0;
          tx_sh = (tx_q.size() > 0) ? tx_q.pop_front() : '0;
        end else begin
          tx_sh = tx_sh << 1;
          ecnt++;
          if (ecnt == W) begin
            ecnt = 0;
            if (tx_q.size() > 0) tx_sh = tx_q.pop_front();
          end
        end
      end
      step_prev = step_o;
      if (done_o) begin
        dones++;
        done_cyc = cyc;
        first = 1'b1;
        rise_in_txn = 0;
      end
      sck_prev = sck_o;
    end
  end

  task automatic clk_n(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // mode: 0 plain, 1 start pulse while busy, 2 start on done cycle, 3 stall at word boundary
  task automatic run_txn(input int dv, input int ln, input int mode, input string tag);
    int nw, s0, r0, d0, gb0, sb0, cb0, budget, st, hi, lat;
    bit poked, stalled, seen_done;
    logic [W-1:0] word;
    nw = (ln == 0) ? 1 : ln;
    s0 = steps; r0 = rises; d0 = dones; gb0 = gap_bad; sb0 = step_bad; cb0 = csn_bad;
    cur_div = dv;
    exp_per = (mode == 3) ? 0 : 2 * (dv + 1);
    for (int i = 0; i < nw; i++) begin
      word = W'($urandom_range(0, 65535));
      tx_q.push_back(word);
      exp_q.push_back(word);
    end
    avail_i = 1'b1;
    div_i   = DW'(dv);
    len_i   = LW'(ln);
    start_i = 1'b1;
    clk_n(1);
    start_i = 1'b0;
    check({tag, "_busy"}, busy_o, 1);
    check({tag, "_csn_early"}, cs_n_o, 1);
    clk_n(1);
    check({tag, "_csn_low"}, cs_n_o, 0);
    poked = 0; stalled = 0; seen_done = 0; budget = 0;
    while (!seen_done && budget < 3000) begin
      if (mode == 1 && !poked && steps - s0 == 5) begin
        poked = 1;
        start_i = 1'b1;
        len_i = LW'(3);
        clk_n(1);
        start_i = 1'b0;
      end
      if (mode == 3 && steps - s0 >= 2 && !stalled) avail_i = 1'b0;
      if (mode == 3 && !stalled && steps - s0 >= W + 1) begin
        stalled = 1;
        st = steps; hi = 0;
        repeat (20) begin
          if (sck_o) hi++;
          clk_n(1);
        end
        check({tag, "_stall_sck"}, hi, 0);
        check({tag, "_stall_steps"}, steps - st, 0);
        avail_i = 1'b1;
        lat = 0;
        while (!sck_o && lat < 20) begin
          clk_n(1);
          lat++;
        end
        check({tag, "_resume_lat"}, (lat >= 1 && lat <= dv + 2), 1);
      end
      if (done_o) begin
        seen_done = 1;
        if (mode == 2) start_i = 1'b1;
      end
      clk_n(1);
      budget++;
    end
    start_i = 1'b0;
    check({tag, "_done_seen"}, seen_done, 1);
    check({tag, "_busy_after"}, busy_o, 0);
    clk_n(8);
    check({tag, "_steps"}, steps - s0, 1 + nw * W);
    check({tag, "_rises"}, rises - r0, nw * W);
    check({tag, "_dones"}, dones - d0, 1);
    check({tag, "_done_lat"}, done_cyc - last_step, dv + 1);
    check({tag, "_gap"}, gap_bad - gb0, 0);
    check({tag, "_step_rule"}, step_bad - sb0, 0);
    check({tag, "_csn_run"}, csn_bad - cb0, 0);
    check({tag, "_sb_left"}, exp_q.size(), 0);
    check({tag, "_idle_csn"}, cs_n_o, 1);
    check({tag, "_idle_sck"}, sck_o, 0);
  endtask

  int s0, budget;

  initial begin
    reset_i = 1'b1; start_i = 1'b0; avail_i = 1'b1; div_i = '0; len_i = '0;
    eng_clr = 1'b1;
    clk_n(3);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_step", step_o, 0);
    check("rst_csn", cs_n_o, 1);
    check("rst_sck", sck_o, 0);
    reset_i = 1'b0;
    eng_clr = 1'b0;
    clk_n(2);

    run_txn(1, 1, 0, "t1");
    run_txn(1, 3, 0, "t2");
    run_txn(1, 2, 3, "t3");
    run_txn(0, 1, 0, "t4");

    // abort in RUN after the load step and 7 falling edges
    s0 = steps;
    cur_div = 1; exp_per = 4;
    tx_q.push_back(16'hA5C3);
    exp_q.push_back(16'hA5C3);
    div_i = 8'd1; len_i = 8'd1; start_i = 1'b1;
    clk_n(1);
    start_i = 1'b0;
    budget = 0;
    while (steps - s0 < 8 && budget < 500) begin
      clk_n(1);
      budget++;
    end
    check("t5_reach", steps - s0, 8);
    check("t5_busy_mid", busy_o, 1);
    reset_i = 1'b1;
    eng_clr = 1'b1;
    clk_n(1);
    check("t5_csn", cs_n_o, 1);
    check("t5_sck", sck_o, 0);
    check("t5_busy", busy_o, 0);
    check("t5_step", step_o, 0);
    reset_i = 1'b0;
    eng_clr = 1'b0;
    tx_q.delete();
    exp_q.delete();
    clk_n(2);
    run_txn(1, 1, 0, "t5b");

    run_txn(2, 1, 1, "t6a");
    run_txn(1, 1, 2, "t6b");
    run_txn(1, 0, 0, "t6c");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
